// File: rtl/date_counter_if.sv
// Purpose: carry, key and date bus between the hour counter / key logic and date_counter.
// Latency: pure wiring, no storage.
// Backpressure: none; every input is a level or a one-cycle pulse.
// Ports: slave  = date_counter side (carry/shift/key/edit inputs, date outputs)
//        master = driving side (opposite directions)
// Optional: DATE_WEEKDAY_EN adds the weekday[2:0] output (0=Monday..6=Sunday).
interface date_counter_if;
   logic       ClkDay;
   logic       ClkHour;
   logic       DayOverPlus;
   logic       DayOverMinus;
   logic       KeyPlus;
   logic       KeyMinus;
   logic       EditMode;
   logic [2:0] EditPos;
   logic [1:0] screen;
   logic [4:0] day;
   logic [3:0] month;
   logic [6:0] year;
   logic       leap;
`ifdef DATE_WEEKDAY_EN
   logic [2:0] weekday;

   modport slave (
      input  ClkDay, ClkHour, DayOverPlus, DayOverMinus,
      input  KeyPlus, KeyMinus, EditMode, EditPos, screen,
      output day, month, year, leap, weekday
   );
   modport master (
      output ClkDay, ClkHour, DayOverPlus, DayOverMinus,
      output KeyPlus, KeyMinus, EditMode, EditPos, screen,
      input  day, month, year, leap, weekday
   );
`else
   modport slave (
      input  ClkDay, ClkHour, DayOverPlus, DayOverMinus,
      input  KeyPlus, KeyMinus, EditMode, EditPos, screen,
      output day, month, year, leap
   );
   modport master (
      output ClkDay, ClkHour, DayOverPlus, DayOverMinus,
      output KeyPlus, KeyMinus, EditMode, EditPos, screen,
      input  day, month, year, leap
   );
`endif
endinterface

// File: rtl/date_counter.sv
// Purpose: calendar day/month/year counter (2000-2099) with carry, time-zone shift and key edit.
// Latency: one cycle; an event sampled on a posedge is visible on the outputs after that edge.
// Backpressure: none; at most one action per cycle, lower-priority events that cycle are dropped.
// Ports: clk, reset (synchronous, active-high); bus = date_counter_if.slave
//        (ClkDay/ClkHour carry, DayOverPlus/Minus shifts, active-low keys, edit controls,
//         day/month/year/leap outputs).
// Optional: DATE_WEEKDAY_EN adds a weekday counter driven onto bus.weekday.
module date_counter #(
   parameter logic [6:0] YEAR_RESET  = 7'd0,
   parameter logic [1:0] SCREEN_DATE = 2'd1
) (
   input  logic          clk,
   input  logic          reset,
   date_counter_if.slave bus
);

   logic [4:0] day_q,   day_d;
   logic [3:0] month_q, month_d;
   logic [6:0] year_q,  year_d;
   logic       leap_q,  leap_d;
   logic       kp_prev_q, km_prev_q;
`ifdef DATE_WEEKDAY_EN
   logic [2:0] wd_q, wd_d;
`endif

   logic       kp_press, km_press;
   logic       do_fwd, do_bwd, do_edit, edit_up;
   logic [4:0] len_cur, len_new;
   logic [3:0] m_new;
   logic [6:0] y_new;
   logic [7:0] step;

   function automatic logic is_leap(input logic [6:0] y);
      is_leap = (y[1:0] == 2'b00);
   endfunction

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
         4'd2:                    month_len = lp ? 5'd29 : 5'd28;
         default:                 month_len = 5'd31;
      endcase
   endfunction

   // v +/- k, wrapped back into [lo..hi] by adding or removing one span.
   function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] k,
                                            input logic [7:0] lo, input logic [7:0] hi,
                                            input logic up);
      logic [7:0] span;
      span = hi - lo + 8'd1;
      if (up) wrap_step = (v + k > hi) ? (v + k - span) : (v + k);
      else    wrap_step = (v < lo + k) ? (v + span - k) : (v - k);
   endfunction

   // History resets low, so a key already held across reset looks "still pressed".
   assign kp_press = !bus.KeyPlus  && kp_prev_q;
   assign km_press = !bus.KeyMinus && km_prev_q;

   assign do_fwd  = (bus.ClkDay && bus.ClkHour && !bus.EditMode) ||
                    (bus.DayOverPlus && bus.EditMode);
   assign do_bwd  = !do_fwd && bus.DayOverMinus && bus.EditMode;
   assign do_edit = !do_fwd && !do_bwd && bus.EditMode && (bus.screen == SCREEN_DATE) &&
                    (kp_press || km_press);
   assign edit_up = kp_press;   // plus wins when both keys fall together

   assign len_cur = month_len(month_q, leap_q);
   assign step    = (bus.EditPos == 3'd7 || bus.EditPos == 3'd4 || bus.EditPos == 3'd1)
                    ? 8'd10 : 8'd1;

   always_comb begin
      day_d   = day_q;
      month_d = month_q;
      year_d  = year_q;
      m_new   = month_q;
      y_new   = year_q;
      len_new = len_cur;
`ifdef DATE_WEEKDAY_EN
      wd_d    = wd_q;
`endif
      if (do_fwd) begin
         if (day_q < len_cur) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d = 5'd1;
            if (month_q == 4'd12) begin
               month_d = 4'd1;
               year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
            end else begin
               month_d = month_q + 4'd1;
            end
         end
`ifdef DATE_WEEKDAY_EN
         wd_d = (wd_q == 3'd6) ? 3'd0 : wd_q + 3'd1;
`endif
      end else if (do_bwd) begin
         if (day_q > 5'd1) begin
            day_d = day_q - 5'd1;
         end else begin
            if (month_q == 4'd1) begin
               m_new = 4'd12;
               y_new = (year_q == 7'd0) ? 7'd99 : year_q - 7'd1;
            end else begin
               m_new = month_q - 4'd1;
            end
            month_d = m_new;
            year_d  = y_new;
            day_d   = month_len(m_new, is_leap(y_new));
         end
`ifdef DATE_WEEKDAY_EN
         wd_d = (wd_q == 3'd0) ? 3'd6 : wd_q - 3'd1;
`endif
      end else if (do_edit) begin
         case (bus.EditPos)
            3'd6, 3'd7: begin
               day_d = 5'(wrap_step({3'b000, day_q}, step, 8'd1, {3'b000, len_cur}, edit_up));
`ifdef DATE_WEEKDAY_EN
               // Only single-day steps track the weekday; tens edits leave it alone.
               if (bus.EditPos == 3'd6)
                  wd_d = edit_up ? ((wd_q == 3'd6) ? 3'd0 : wd_q + 3'd1)
                                 : ((wd_q == 3'd0) ? 3'd6 : wd_q - 3'd1);
`endif
            end
            3'd3, 3'd4: begin
               m_new   = 4'(wrap_step({4'b0000, month_q}, step, 8'd1, 8'd12, edit_up));
               month_d = m_new;
            end
            3'd0, 3'd1: begin
               y_new  = 7'(wrap_step({1'b0, year_q}, step, 8'd0, 8'd99, edit_up));
               year_d = y_new;
            end
            default: ;
         endcase
         // A month/year change can shorten the month under the current day.
         len_new = month_len(m_new, is_leap(y_new));
         if (day_d > len_new) day_d = len_new;
      end
      leap_d = is_leap(year_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         day_q     <= 5'd1;
         month_q   <= 4'd1;
         year_q    <= YEAR_RESET;
         leap_q    <= is_leap(YEAR_RESET);
         kp_prev_q <= 1'b0;
         km_prev_q <= 1'b0;
`ifdef DATE_WEEKDAY_EN
         wd_q      <= 3'd5;   // 01-01-2000 was a Saturday
`endif
      end else begin
         day_q     <= day_d;
         month_q   <= month_d;
         year_q    <= year_d;
         leap_q    <= leap_d;
         kp_prev_q <= bus.KeyPlus;
         km_prev_q <= bus.KeyMinus;
`ifdef DATE_WEEKDAY_EN
         wd_q      <= wd_d;
`endif
      end
   end

   assign bus.day   = day_q;
   assign bus.month = month_q;
   assign bus.year  = year_q;
   assign bus.leap  = leap_q;
`ifdef DATE_WEEKDAY_EN
   assign bus.weekday = wd_q;
`endif

endmodule

// File: tb/tb_date_counter.sv
// Purpose: directed self-checking bench for date_counter (carry, shifts, edits, reset/key hold).
// Latency: inputs driven on negedge, outputs checked on a later negedge.
// Backpressure: n/a.
module tb_date_counter;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   date_counter_if bus ();

   date_counter #(
      .YEAR_RESET  (7'd0),
      .SCREEN_DATE (2'd1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_date(input string tag, input int d, input int m, input int y);
      check({tag, ".day"},   int'(bus.day),   d);
      check({tag, ".month"}, int'(bus.month), m);
      check({tag, ".year"},  int'(bus.year),  y);
      check({tag, ".leap"},  int'(bus.leap),  (y % 4 == 0) ? 1 : 0);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit plus);
      if (plus) bus.KeyPlus = 1'b0;
      else      bus.KeyMinus = 1'b0;
      tick(1);
      bus.KeyPlus  = 1'b1;
      bus.KeyMinus = 1'b1;
      tick(1);
   endtask

   task automatic edit(input logic [2:0] pos, input bit plus, input int n);
      bus.EditPos = pos;
      for (int i = 0; i < n; i++) press(plus);
   endtask

   task automatic carry();
      bus.ClkDay  = 1'b1;
      bus.ClkHour = 1'b1;
      tick(1);
      bus.ClkDay  = 1'b0;
      bus.ClkHour = 1'b0;
      tick(1);
   endtask

   task automatic shift(input bit plus);
      if (plus) bus.DayOverPlus = 1'b1;
      else      bus.DayOverMinus = 1'b1;
      tick(1);
      bus.DayOverPlus  = 1'b0;
      bus.DayOverMinus = 1'b0;
      tick(1);
   endtask

   initial begin
      reset            = 1'b1;
      bus.ClkDay       = 1'b0;
      bus.ClkHour      = 1'b0;
      bus.DayOverPlus  = 1'b0;
      bus.DayOverMinus = 1'b0;
      bus.KeyPlus      = 1'b1;
      bus.KeyMinus     = 1'b1;
      bus.EditMode     = 1'b0;
      bus.EditPos      = 3'd0;
      bus.screen       = 2'd1;
      tick(3);
      reset = 1'b0;
      check_date("reset", 1, 1, 0);
`ifdef DATE_WEEKDAY_EN
      check("reset.weekday", int'(bus.weekday), 5);
`endif

      // Hour carry advances one day; ClkHour alone does nothing.
      carry();
      check_date("carry1", 2, 1, 0);
`ifdef DATE_WEEKDAY_EN
      check("carry1.weekday", int'(bus.weekday), 6);
`endif
      bus.ClkHour = 1'b1;
      tick(1);
      bus.ClkHour = 1'b0;
      tick(1);
      check_date("hour_only", 2, 1, 0);

      // Leap February roll-over, year 00.
      bus.EditMode = 1'b1;
      edit(3'd3, 1'b1, 1);
      edit(3'd7, 1'b1, 2);
      edit(3'd6, 1'b1, 6);
      check_date("set_28_02_00", 28, 2, 0);
      bus.EditMode = 1'b0;
      carry();
      check_date("fwd_29_02_00", 29, 2, 0);
      carry();
      check_date("fwd_01_03_00", 1, 3, 0);

      // Non-leap February, year 01.
      bus.EditMode = 1'b1;
      edit(3'd0, 1'b1, 1);
      edit(3'd3, 1'b0, 1);
      edit(3'd6, 1'b0, 1);
      check_date("set_28_02_01", 28, 2, 1);
      bus.EditMode = 1'b0;
      carry();
      check_date("fwd_01_03_01", 1, 3, 1);

      // Backward across the century and forward again.
      bus.EditMode = 1'b1;
      edit(3'd0, 1'b0, 1);
      edit(3'd3, 1'b0, 2);
      check_date("set_01_01_00", 1, 1, 0);
      shift(1'b0);
      check_date("bwd_31_12_99", 31, 12, 99);
      shift(1'b1);
      check_date("fwd_01_01_00", 1, 1, 0);
      bus.EditMode = 1'b0;
      shift(1'b0);
      check_date("dom_ignored", 1, 1, 0);
      bus.EditMode = 1'b1;
      carry();
      check_date("carry_ignored", 1, 1, 0);

      // Field edits with wrap and clamp.
      edit(3'd0, 1'b1, 1);
      edit(3'd6, 1'b0, 1);
      check_date("set_31_01_01", 31, 1, 1);
      edit(3'd3, 1'b1, 1);
      check_date("month_clamp", 28, 2, 1);
      edit(3'd0, 1'b0, 1);
      edit(3'd3, 1'b1, 1);
      edit(3'd7, 1'b0, 1);
      edit(3'd6, 1'b0, 3);
      check_date("set_15_03_00", 15, 3, 0);
      edit(3'd4, 1'b1, 1);
      check_date("month_tens_wrap", 15, 1, 0);
      edit(3'd7, 1'b0, 1);
      check_date("day_tens_minus", 5, 1, 0);
      edit(3'd7, 1'b0, 1);
      check_date("day_tens_wrap", 26, 1, 0);
      edit(3'd7, 1'b1, 1);
      check_date("day_tens_plus_wrap", 5, 1, 0);
      edit(3'd1, 1'b0, 1);
      check_date("year_tens_wrap", 5, 1, 90);
      edit(3'd1, 1'b1, 1);
      check_date("year_tens_back", 5, 1, 0);
      edit(3'd2, 1'b1, 1);
      check_date("pos2_noop", 5, 1, 0);
      bus.screen = 2'd0;
      edit(3'd6, 1'b1, 1);
      check_date("wrong_screen", 5, 1, 0);
      bus.screen = 2'd1;
      edit(3'd4, 1'b0, 1);
      check_date("month_tens_minus", 5, 3, 0);

      // Both keys together: plus wins.
      bus.EditPos  = 3'd6;
      bus.KeyPlus  = 1'b0;
      bus.KeyMinus = 1'b0;
      tick(1);
      bus.KeyPlus  = 1'b1;
      bus.KeyMinus = 1'b1;
      tick(1);
      check_date("both_keys", 6, 3, 0);

      // Shift beats a key press in the same cycle.
      bus.DayOverPlus = 1'b1;
      bus.KeyMinus    = 1'b0;
      tick(1);
      bus.DayOverPlus = 1'b0;
      bus.KeyMinus    = 1'b1;
      tick(1);
      check_date("dop_over_key", 7, 3, 0);
      bus.DayOverMinus = 1'b1;
      bus.KeyPlus      = 1'b0;
      tick(1);
      bus.DayOverMinus = 1'b0;
      bus.KeyPlus      = 1'b1;
      tick(1);
      check_date("dom_over_key", 6, 3, 0);

      // Long hold gives one event.
      bus.KeyPlus = 1'b0;
      tick(20);
      check_date("hold_low", 7, 3, 0);
      bus.KeyPlus = 1'b1;
      tick(1);
      check_date("hold_release", 7, 3, 0);

      // Out of edit mode, only the carry acts.
      bus.EditMode = 1'b0;
      bus.KeyPlus  = 1'b0;
      bus.ClkDay   = 1'b1;
      bus.ClkHour  = 1'b1;
      tick(1);
      bus.ClkDay   = 1'b0;
      bus.ClkHour  = 1'b0;
      bus.KeyPlus  = 1'b1;
      tick(1);
      check_date("carry_vs_key", 8, 3, 0);

      // Year change clamps 29 Feb into a non-leap year.
      bus.EditMode = 1'b1;
      edit(3'd3, 1'b0, 1);
      edit(3'd7, 1'b1, 2);
      edit(3'd6, 1'b1, 1);
      check_date("set_29_02_00", 29, 2, 0);
      edit(3'd0, 1'b0, 1);
      check_date("year_clamp", 28, 2, 99);

      // Reset mid-edit with KeyMinus held: no event until a fresh press.
      bus.EditPos  = 3'd6;
      bus.KeyMinus = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(5);
      check_date("reset_key_held", 1, 1, 0);
`ifdef DATE_WEEKDAY_EN
      check("reset2.weekday", int'(bus.weekday), 5);
`endif
      bus.KeyMinus = 1'b1;
      tick(1);
      press(1'b0);
      check_date("after_repress", 31, 1, 0);
`ifdef DATE_WEEKDAY_EN
      check("repress.weekday", int'(bus.weekday), 4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
